// File: rtl/bf_pkg.sv
// bf_pkg: shared opcode bytes, terminator and loader state encoding for the BF program loader.
package bf_pkg;
    localparam logic [7:0] OP_INC     = 8'h2B;
    localparam logic [7:0] OP_DEC     = 8'h2D;
    localparam logic [7:0] OP_LEFT    = 8'h3C;
    localparam logic [7:0] OP_RIGHT   = 8'h3E;
    localparam logic [7:0] OP_OPEN    = 8'h5B;
    localparam logic [7:0] OP_CLOSE   = 8'h5D;
    localparam logic [7:0] OP_OUT     = 8'h2E;
    localparam logic [7:0] OP_IN      = 8'h2C;
    localparam logic [7:0] CH_HASH    = 8'h23;
    localparam logic [7:0] CH_NEWLINE = 8'h0A;
    localparam logic [7:0] TERM_BYTE  = 8'h00;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TERM, S_RUN, S_ERROR} loader_state_t;
endpackage

// File: rtl/bf_char_decode.sv
// bf_char_decode: classifies a byte as BF opcode / bracket; hash and newline flags exist only with BF_LOADER_COMMENT_EN.
module bf_char_decode
    import bf_pkg::*;
(
    input  logic [7:0] i_data,
    output logic       o_is_opcode,
    output logic       o_is_open,
    output logic       o_is_close
`ifdef BF_LOADER_COMMENT_EN
    ,
    output logic       o_is_hash,
    output logic       o_is_newline
`endif
);
    assign o_is_open   = i_data == OP_OPEN;
    assign o_is_close  = i_data == OP_CLOSE;
    assign o_is_opcode = o_is_open | o_is_close | (i_data == OP_INC) | (i_data == OP_DEC) |
                         (i_data == OP_LEFT) | (i_data == OP_RIGHT) | (i_data == OP_OUT) | (i_data == OP_IN);
`ifdef BF_LOADER_COMMENT_EN
    assign o_is_hash    = i_data == CH_HASH;
    assign o_is_newline = i_data == CH_NEWLINE;
`endif
endmodule

// File: rtl/bf_program_loader.sv
// bf_program_loader: filters UART bytes to BF opcodes, stores them with a 0x00 terminator, checks brackets/capacity; '#' comments with BF_LOADER_COMMENT_EN.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int PROG_ADDR_SIZE = 4,
    parameter int DEPTH_SIZE     = 4
)
(
    input  logic                      i_sys_clk,
    input  logic                      i_reset,
    input  logic                      i_loading,
    input  logic                      i_rx_valid,
    input  logic [7:0]                i_rx_data,
    output logic                      o_mem_we,
    output logic [PROG_ADDR_SIZE-1:0] o_mem_addr,
    output logic [7:0]                o_mem_data,
    output logic                      o_proc_run,
    output logic [PROG_ADDR_SIZE-1:0] o_prog_len,
    output logic                      o_overflow,
    output logic                      o_unbalanced,
    output logic                      o_busy
);
    localparam logic [PROG_ADDR_SIZE-1:0] ADDR_MAX  = '1;
    localparam logic [DEPTH_SIZE-1:0]     DEPTH_MAX = '1;

    loader_state_t             r_state, w_state;
    logic [PROG_ADDR_SIZE-1:0] r_addr, w_addr, r_mem_addr, w_mem_addr, r_prog_len, w_prog_len;
    logic [DEPTH_SIZE-1:0]     r_depth, w_depth;
    logic [7:0]                r_mem_data, w_mem_data;
    logic                      r_mem_we, w_mem_we, r_overflow, w_overflow, r_unbalanced, w_unbalanced;
    logic                      r_proc_run, r_busy;
    logic                      w_is_opcode, w_is_open, w_is_close, w_accept;
`ifdef BF_LOADER_COMMENT_EN
    logic                      r_comment, w_comment, w_is_hash, w_is_newline;
`endif

    bf_char_decode u_decode (
        .i_data       (i_rx_data),
        .o_is_opcode  (w_is_opcode),
        .o_is_open    (w_is_open),
`ifdef BF_LOADER_COMMENT_EN
        .o_is_close   (w_is_close),
        .o_is_hash    (w_is_hash),
        .o_is_newline (w_is_newline)
`else
        .o_is_close   (w_is_close)
`endif
    );

`ifdef BF_LOADER_COMMENT_EN
    assign w_accept = i_rx_valid & w_is_opcode & ~r_comment;
`else
    assign w_accept = i_rx_valid & w_is_opcode;
`endif

    // Next state and next register values; everything holds unless a state rule changes it.
    always_comb begin
        w_state      = r_state;
        w_addr       = r_addr;
        w_depth      = r_depth;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_data   = r_mem_data;
        w_prog_len   = r_prog_len;
        w_overflow   = r_overflow;
        w_unbalanced = r_unbalanced;
`ifdef BF_LOADER_COMMENT_EN
        w_comment    = r_comment;
`endif
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (i_loading) begin
                    w_state      = S_LOAD;
                    w_addr       = '0;
                    w_depth      = '0;
                    w_prog_len   = '0;
                    w_overflow   = 1'b0;
                    w_unbalanced = 1'b0;
`ifdef BF_LOADER_COMMENT_EN
                    w_comment    = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (!i_loading) begin
                    w_state      = S_TERM;
                    w_mem_we     = 1'b1;
                    w_mem_addr   = r_addr;
                    w_mem_data   = TERM_BYTE;
                    w_prog_len   = r_addr;
                    w_unbalanced = r_unbalanced | (r_depth != '0);
                end else begin
`ifdef BF_LOADER_COMMENT_EN
                    if (i_rx_valid && r_comment && w_is_newline)
                        w_comment = 1'b0;
                    else if (i_rx_valid && !r_comment && w_is_hash)
                        w_comment = 1'b1;
`endif
                    if (w_accept) begin
                        if (r_addr != ADDR_MAX) begin
                            w_mem_we   = 1'b1;
                            w_mem_addr = r_addr;
                            w_mem_data = i_rx_data;
                            w_addr     = r_addr + 1'b1;
                        end else begin
                            w_overflow = 1'b1;
                        end
                        if (w_is_open) begin
                            if (r_depth == DEPTH_MAX) w_unbalanced = 1'b1;
                            else w_depth = r_depth + 1'b1;
                        end
                        if (w_is_close) begin
                            if (r_depth == '0) w_unbalanced = 1'b1;
                            else w_depth = r_depth - 1'b1;
                        end
                    end
                end
            end
            S_TERM:  w_state = (r_overflow | r_unbalanced) ? S_ERROR : S_RUN;
            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers; proc_run/busy are registered decodes of the next state.
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_depth      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_prog_len   <= '0;
            r_overflow   <= 1'b0;
            r_unbalanced <= 1'b0;
            r_proc_run   <= 1'b0;
            r_busy       <= 1'b0;
`ifdef BF_LOADER_COMMENT_EN
            r_comment    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_addr       <= w_addr;
            r_depth      <= w_depth;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_data   <= w_mem_data;
            r_prog_len   <= w_prog_len;
            r_overflow   <= w_overflow;
            r_unbalanced <= w_unbalanced;
            r_proc_run   <= w_state == S_RUN;
            r_busy       <= (w_state == S_LOAD) || (w_state == S_TERM);
`ifdef BF_LOADER_COMMENT_EN
            r_comment    <= w_comment;
`endif
        end
    end

    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_prog_len   = r_prog_len;
    assign o_overflow   = r_overflow;
    assign o_unbalanced = r_unbalanced;
    assign o_proc_run   = r_proc_run;
    assign o_busy       = r_busy;
endmodule

// File: tb/tb_bf_program_loader.sv
// tb_bf_program_loader: random and directed program uploads checked against a behavioural upload model.
module tb_bf_program_loader;
    typedef byte unsigned bq_t[$];
    localparam int CAP  = 15;
    localparam int DMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loading = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       mem_we, proc_run, overflow, unbalanced, busy;
    logic [3:0] mem_addr, prog_len;
    logic [7:0] mem_data;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [11:0] wr_q[$];
    string      alpha = "+-<>[].,#\nax ";

    bf_program_loader dut (
        .i_sys_clk    (clk),
        .i_reset      (rst_n),
        .i_loading    (loading),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .o_proc_run   (proc_run),
        .o_prog_len   (prog_len),
        .o_overflow   (overflow),
        .o_unbalanced (unbalanced),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_op(byte unsigned b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
    endfunction

    function automatic bq_t str2q(string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rep(byte unsigned b, int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(b);
        return q;
    endfunction

    task automatic run_load(input string tag, input bq_t bytes, input bit tail_rx);
        bq_t ops;
        int  nops = 0;
        int  d = 0;
        int  k = 0;
        bit  unb = 0;
        bit  cm = 0;
        bit  ovf;
        foreach (bytes[i]) begin
            byte unsigned b = bytes[i];
`ifdef BF_LOADER_COMMENT_EN
            if (cm) begin
                if (b == 8'h0A) cm = 0;
                continue;
            end
            if (b == 8'h23) begin
                cm = 1;
                continue;
            end
`endif
            if (!is_op(b)) continue;
            nops++;
            if (nops <= CAP) ops.push_back(b);
            if (b == 8'h5B) begin
                if (d == DMAX) unb = 1; else d++;
            end
            if (b == 8'h5D) begin
                if (d == 0) unb = 1; else d--;
            end
        end
        if (d != 0) unb = 1;
        ovf = nops > CAP;
        wr_q.delete();
        @(posedge clk); #1 loading = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_load"}, busy, 1);
        check({tag, "_flags_clr"}, {overflow, unbalanced}, 0);
        check({tag, "_len_clr"}, prog_len, 0);
        check({tag, "_run_load"}, proc_run, 0);
        foreach (bytes[i]) begin
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2) == 0 ? 1 : 0) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rx_valid = tail_rx;
        rx_data  = 8'h2B;
        loading  = 1'b0;
        @(posedge clk); #1 rx_valid = 1'b0;
        while (busy && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_nwrites"}, wr_q.size(), ops.size() + 1);
        for (int i = 0; i <= ops.size() && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], {i[3:0], (i < ops.size()) ? ops[i] : 8'h00});
        check({tag, "_prog_len"}, prog_len, ops.size());
        check({tag, "_overflow"}, overflow, ovf);
        check({tag, "_unbalanced"}, unbalanced, unb);
        check({tag, "_proc_run"}, proc_run, !(ovf || unb));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {mem_we, mem_addr, mem_data, proc_run, prog_len, overflow, unbalanced, busy}, 0);
        rst_n = 1'b1;
        run_load("basic", str2q("+[.+]"), 0);
        run_load("filter", str2q("a+ b\n-"), 1);
        run_load("ovf16", rep(8'h2B, 16), 0);
        run_load("unbal", str2q("]+"), 0);
        run_load("reload", str2q("[]"), 0);
        run_load("comment", str2q("+#+-\n-"), 0);
        run_load("empty", str2q(""), 1);
        run_load("full15", rep(8'h2B, 15), 0);
        run_load("sat16", rep(8'h5B, 16), 0);
        run_load("open", str2q("[[+]"), 0);
        wr_q.delete();
        @(posedge clk); #1 loading = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h2D;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outs", {mem_we, mem_addr, mem_data, proc_run, prog_len, overflow, unbalanced, busy}, 0);
        rst_n = 1'b1;
        loading = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_nwrites", wr_q.size(), 3);
        check("midrst_idle", {busy, proc_run}, 0);
        for (int t = 0; t < 40; t++) begin
            bq_t q;
            int  n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            run_load($sformatf("rnd%0d", t), q, $urandom_range(0, 1));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bf_program_loader.md
Name: bf_program_loader

Overview:
Sequencer between the UART receiver and the brainfuck processor's program memory. While `loading` is high it filters received bytes down to the eight BF opcodes and writes them to consecutive program addresses. It also tracks bracket balance and checks capacity. When loading ends it writes a 0x00 end marker, then either releases the processor (`procRun`) or latches an error.

Parameters:
progAddrSize, 4, program memory address width; capacity is 2^progAddrSize-1 opcodes plus one terminator slot
depthSize, 4, bracket-depth counter width

Ports:
sysClk  in  1  system clock
reset  in  1  synchronous, active-low reset
loading  in  1  level; high = program upload window open
rxValid  in  1  one-cycle strobe, byte received
rxData  in  8  received byte, valid with rxValid
memWe  out  1  program memory write enable, one cycle per write
memAddr  out  progAddrSize  program memory write address
memData  out  8  program memory write data
procRun  out  1  high = processor may execute (drives processor reset release)
progLen  out  progAddrSize  number of opcodes stored by last load
overflow  out  1  sticky: more opcodes than capacity
unbalanced  out  1  sticky: unmatched '[' or ']'
busy  out  1  high in LOAD and TERM

Behaviour:
- Reset (reset==0 at a sysClk edge): state=IDLE; memWe=0, memAddr=0, memData=0, procRun=0, progLen=0, overflow=0, unbalanced=0, busy=0; internal addr=0, depth=0. Reset mid-load abandons the load; no terminator is written.
- All outputs are registered. A write appears on memWe/memAddr/memData exactly 1 cycle after the accepting rxValid. Back-to-back rxValid every cycle is accepted.
- Opcode set: 0x2B '+', 0x2D '-', 0x3C '<', 0x3E '>', 0x5B '[', 0x5D ']', 0x2E '.', 0x2C ','. All other bytes are dropped silently.
- States:
  - IDLE: all outputs held. loading==1 -> LOAD, which clears addr, depth, overflow, unbalanced and progLen.
  - LOAD: busy=1.
    - Opcode with addr < 2^N-1: write at addr, then addr++.
    - Opcode with addr == 2^N-1: not written; overflow=1.
    - '[': depth++. Saturates at max; saturation sets unbalanced.
    - ']' with depth==0: unbalanced=1. Otherwise depth--.
    - Bracket tracking applies even to overflowed opcodes.
    - loading==0 -> TERM. An rxValid in that same cycle is ignored.
  - TERM (1 cycle): memWe=1, memAddr=addr, memData=0x00; progLen=addr. Exits on depth!=0 -> unbalanced=1.
    - overflow|unbalanced (after that update) -> ERROR; else -> RUN.
  - RUN: procRun=1. loading==1 -> LOAD; procRun deasserts on the same edge.
  - ERROR: procRun=0; flags held. loading==1 -> LOAD, which clears the flags.
- Empty program (no opcodes): TERM writes 0x00 at address 0, progLen=0, -> RUN.
- Exactly 2^N-1 opcodes: no overflow; terminator lands at address 2^N-1.
- addr never wraps.

Optional Feature:
BF_LOADER_COMMENT_EN
- Defined: '#' (0x23) enters comment mode; all bytes up to and including 0x0A are dropped, even opcodes. Comment mode clears on entry to LOAD and on reset.
- Not defined: '#' is an ordinary non-opcode byte and is dropped; no comment state exists.

Decomposition:
- Package bf_pkg holds:
  - the opcode byte constants;
  - the terminator constant 8'h00;
  - the loader state encoding (IDLE, LOAD, TERM, RUN, ERROR).
- One sub-module, bf_char_decode: combinational classifier from rxData to isOpcode, isOpen, isClose (plus isHash and isNewline under the macro). It is shared with the processor's instruction decoder.

Test Plan:
- Reset, loading=1, send "+[.+]", loading=0 -> writes 2B,5B,2E,2B,5D at 0..4 then 00 at 5; progLen=5; procRun=1; flags 0.
- Send "a+ b\n-" -> only 2B@0, 2D@1, 00@2 written; progLen=2.
- N=4, send 16 '+' -> 15 writes at 0..14, 00@15, overflow=1, state ERROR, procRun=0.
- Send "]+" -> unbalanced=1, ERROR. Then reload "[]" -> flags clear, RUN, progLen=2.
- Assert reset mid-load after 3 opcodes -> all outputs 0 next cycle, no 00 written, IDLE.
- With BF_LOADER_COMMENT_EN, send "+#+-\n-" -> 2B@0, 2D@1, 00@2. Without the macro: 2B,2B,2D,2D then 00@4.
